wide_mult_axi_legup_mult_pipe: RTL and testbench

WIDE_MULT_AXI_LEGUP_MULT_PIPE -- requirements
Module: wide_mult_axi_legup_mult_pipe

---
 rtl/wide_mult_axi_legup_mult_pipe.sv | 128 ++++++++++++
 tb/tb_wide_mult_axi_legup_mult_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_mult_axi_legup_mult_pipe.sv
// Pipelined multiplier with valid/ready handshake and one global stall (advance).
// Stage 1 registers the operands; stages 2..pipeline carry the product and valid bit.
module wide_mult_axi_legup_mult_pipe #(
   parameter int    widtha         = 32,
   parameter int    widthb         = 32,
   parameter int    widthp         = 64,
   parameter string representation = "UNSIGNED",
   parameter int    pipeline       = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [widtha-1:0] dataa,
   input  logic [widthb-1:0] datab,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [widthp-1:0] result,
   output logic              busy
);
   localparam int FW        = widtha + widthb;
   localparam int XW        = (widthp > FW) ? widthp : FW;
   localparam bit IS_SIGNED = (representation == "SIGNED");

   if ((pipeline < 1) || (pipeline > 8)) begin : g_bad_pipeline
      $error("wide_mult_axi_legup_mult_pipe: pipeline must be within 1..8");
   end
   if ((representation != "UNSIGNED") && (representation != "SIGNED")) begin : g_bad_repr
      $error("wide_mult_axi_legup_mult_pipe: representation must be UNSIGNED or SIGNED");
   end

   // Keeps the LSBs of the full product, extending with its sign bit only in SIGNED mode.
   function automatic logic [widthp-1:0] resize_product(input logic [FW-1:0] full);
      logic [XW-1:0] ext;
      ext = {XW{IS_SIGNED && full[FW-1]}};
      ext[FW-1:0] = full;
      return ext[widthp-1:0];
   endfunction

   logic [widtha-1:0]   a_q, a_d;
   logic [widthb-1:0]   b_q, b_d;
   logic [pipeline-1:0] vld_q, vld_d;
   logic                advance_s;
   logic [FW-1:0]       ax_s, bx_s, full_s;
   logic [widthp-1:0]   prod_s;

   assign advance_s = !out_valid || out_ready;
   assign in_ready  = advance_s;
   assign out_valid = vld_q[pipeline-1];
   assign busy      = |vld_q;

   // Operands are widened to the full product width so one unsigned multiply serves both modes.
   always_comb begin
      ax_s = {FW{IS_SIGNED && a_q[widtha-1]}};
      ax_s[widtha-1:0] = a_q;
      bx_s = {FW{IS_SIGNED && b_q[widthb-1]}};
      bx_s[widthb-1:0] = b_q;
      full_s = ax_s * bx_s;
      prod_s = resize_product(full_s);
   end

   // Stage-1 operand capture and valid-bit shift, all gated by advance.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      vld_d = vld_q;
      if (advance_s) begin
         a_d      = dataa;
         b_d      = datab;
         vld_d[0] = in_valid;
         for (int i = 1; i < pipeline; i++) begin
            vld_d[i] = vld_q[i-1];
         end
      end else begin
         a_d   = a_q;
         b_d   = b_q;
         vld_d = vld_q;
      end
   end

   // Stage-1 and valid registers; reset discards everything in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_q   <= {widtha{1'b0}};
         b_q   <= {widthb{1'b0}};
         vld_q <= {pipeline{1'b0}};
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         vld_q <= vld_d;
      end
   end

   if (pipeline == 1) begin : g_comb_out
      assign result = prod_s;
   end else begin : g_reg_out
      localparam int DEPTH = pipeline - 1;
      logic [widthp-1:0] pq_q [DEPTH];
      logic [widthp-1:0] pq_d [DEPTH];

      // Product shift chain behind stage 1.
      always_comb begin
         pq_d = pq_q;
         if (advance_s) begin
            pq_d[0] = prod_s;
            for (int i = 1; i < DEPTH; i++) begin
               pq_d[i] = pq_q[i-1];
            end
         end else begin
            pq_d = pq_q;
         end
      end

      // Product stage registers.
      always_ff @(posedge clock) begin
         if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
               pq_q[i] <= {widthp{1'b0}};
            end
         end else begin
            pq_q <= pq_d;
         end
      end

      assign result = pq_q[DEPTH-1];
   end

endmodule

// File: tb/tb_wide_mult_axi_legup_mult_pipe.sv
// Scoreboard bench: three configurations (unsigned/64/pipe3, signed/80/pipe1, unsigned 16x16->16/pipe2)
// share one stimulus stream; a negedge monitor pushes expected products on acceptance and pops on output.
module tb_wide_mult_axi_legup_mult_pipe;
   logic        clock;
   logic        reset;
   logic        in_valid;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic        out_ready;

   logic        in_ready0, out_valid0, busy0;
   logic [63:0] result0;
   logic        in_ready1, out_valid1, busy1;
   logic [79:0] result1;
   logic        in_ready2, out_valid2, busy2;
   logic [15:0] result2;

   int n_cmp = 0;
   int n_err = 0;
   int n_out0 = 0;
   int n_out1 = 0;

   logic [63:0] q0[$];
   logic [79:0] q1[$];
   logic [15:0] q2[$];
   logic [63:0] held0;
   bit          hold0_v = 1'b0;

   wide_mult_axi_legup_mult_pipe #(.widtha(32), .widthb(32), .widthp(64),
      .representation("UNSIGNED"), .pipeline(3)) u_dut0 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .dataa(dataa), .datab(datab), .out_valid(out_valid0), .out_ready(out_ready),
      .result(result0), .busy(busy0));

   wide_mult_axi_legup_mult_pipe #(.widtha(32), .widthb(32), .widthp(80),
      .representation("SIGNED"), .pipeline(1)) u_dut1 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .dataa(dataa), .datab(datab), .out_valid(out_valid1), .out_ready(out_ready),
      .result(result1), .busy(busy1));

   wide_mult_axi_legup_mult_pipe #(.widtha(16), .widthb(16), .widthp(16),
      .representation("UNSIGNED"), .pipeline(2)) u_dut2 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .dataa(dataa[15:0]), .datab(datab[15:0]), .out_valid(out_valid2), .out_ready(out_ready),
      .result(result2), .busy(busy2));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: plain integer arithmetic on the operand values.
   function automatic logic [63:0] model0(input logic [31:0] a, input logic [31:0] b);
      longint unsigned x, y;
      x = {32'd0, a};
      y = {32'd0, b};
      return x * y;
   endfunction

   function automatic logic [79:0] model1(input logic [31:0] a, input logic [31:0] b);
      int     sa, sb;
      longint p;
      sa = a;
      sb = b;
      p  = longint'(sa) * longint'(sb);
      return {{16{p[63]}}, p};
   endfunction

   function automatic logic [15:0] model2(input logic [31:0] a, input logic [31:0] b);
      int unsigned x, y, p;
      x = {16'd0, a[15:0]};
      y = {16'd0, b[15:0]};
      p = x * y;
      return p[15:0];
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: output transfers are popped first, then the upcoming input transfer is pushed.
   always @(negedge clock) begin
      if (reset) begin
         q0.delete();
         q1.delete();
         q2.delete();
         hold0_v = 1'b0;
      end else begin
         if (hold0_v) begin
            check("stall_valid0", out_valid0, 1'b1);
            check("stall_hold0", result0, held0);
         end
         hold0_v = out_valid0 && !out_ready;
         held0   = result0;
         check("in_ready0", in_ready0, !out_valid0 || out_ready);
         check("in_ready1", in_ready1, !out_valid1 || out_ready);
         check("in_ready2", in_ready2, !out_valid2 || out_ready);
         if (out_valid0 && out_ready) begin
            n_out0++;
            if (q0.size() == 0) check("unexpected0", result0, 128'hx);
            else check("result0", result0, q0.pop_front());
         end
         if (out_valid1 && out_ready) begin
            n_out1++;
            if (q1.size() == 0) check("unexpected1", result1, 128'hx);
            else check("result1", result1, q1.pop_front());
         end
         if (out_valid2 && out_ready) begin
            if (q2.size() == 0) check("unexpected2", result2, 128'hx);
            else check("result2", result2, q2.pop_front());
         end
         if (in_valid && in_ready0) q0.push_back(model0(dataa, datab));
         if (in_valid && in_ready1) q1.push_back(model1(dataa, datab));
         if (in_valid && in_ready2) q2.push_back(model2(dataa, datab));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic single_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] e0, input logic [79:0] e1, input logic [15:0] e2);
      dataa = a; datab = b; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         check("latency0", out_valid0, k == 3);
         check("latency1", out_valid1, k == 1);
         check("latency2", out_valid2, k == 2);
         if (k == 3) check("single_res0", result0, e0);
         if (k == 1) check("single_res1", result1, e1);
         if (k == 2) check("single_res2", result2, e2);
         tick();
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while ((busy0 || busy1 || busy2) && (t < 50)) begin
         tick();
         t++;
      end
      check("drain_busy", {busy0, busy1, busy2}, 3'b000);
      check("drain_q0", q0.size(), 0);
      check("drain_q1", q1.size(), 0);
      check("drain_q2", q2.size(), 0);
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid0"}, out_valid0, 1'b0);
      check({name, "_busy0"}, busy0, 1'b0);
      check({name, "_result0"}, result0, 64'd0);
      check({name, "_valid1"}, out_valid1, 1'b0);
      check({name, "_result1"}, result1, 80'd0);
      check({name, "_busy2"}, busy2, 1'b0);
      check({name, "_result2"}, result2, 16'd0);
      check({name, "_in_ready0"}, in_ready0, 1'b1);
   endtask

   initial begin
      int  idx, c, base0, base1;
      bit  acc;
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      dataa = 32'h1234_5678; datab = 32'h9ABC_DEF0;
      repeat (3) tick();
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      check_idle("reset");

      single_op(32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE,
                80'hFFFF_FFFF_FFFF_FFFF_FFFE, 16'hFFFE);
      single_op(32'hFFFF_FFFD, 32'h0000_0007, 64'h0000_0006_FFFF_FFEB,
                80'hFFFF_FFFF_FFFF_FFFF_FFEB, 16'hFFEB);
      single_op(32'h0000_1234, 32'h0000_0100, 64'h0000_0000_0012_3400,
                80'h0000_0000_0000_0012_3400, 16'h3400);

      // Ten back-to-back pairs with the consumer stalled on cycles 5..8.
      base0 = n_out0; idx = 0; c = 0;
      while ((idx < 10) && (c < 40)) begin
         in_valid = 1'b1; dataa = idx; datab = idx + 1;
         out_ready = !((c >= 5) && (c <= 8));
         @(negedge clock);
         if ((c >= 5) && (c <= 8)) check("bp_in_ready0", in_ready0, 1'b0);
         acc = in_valid && in_ready0;
         tick();
         if (acc) idx++;
         c++;
      end
      drain();
      check("bp_count0", n_out0 - base0, 10);

      // pipeline=1 instance: one product per cycle with simultaneous in/out transfers.
      base1 = n_out1;
      for (int k = 0; k < 30; k++) begin
         in_valid = 1'b1; dataa = $urandom; datab = $urandom; out_ready = 1'b1;
         @(negedge clock);
         check("tput_valid1", out_valid1, k > 0);
         check("tput_ready1", in_ready1, 1'b1);
         tick();
      end
      drain();
      check("tput_count1", n_out1 - base1, 30);

      // Three pairs in flight, then a one-cycle reset with a pair presented during it.
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; dataa = pick(); datab = pick(); out_ready = 1'b1;
         tick();
      end
      reset = 1'b1; dataa = 32'hDEAD_BEEF; datab = 32'h0000_0003;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      check_idle("midreset");
      single_op(32'd5, 32'd9, 64'd45, 80'd45, 16'd45);

      // Randomized traffic with random backpressure; the source holds a pair until accepted.
      acc = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            dataa = pick(); datab = pick();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
         acc = in_valid && in_ready0;
         tick();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
